// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets several byte sources share one UART
// transmitter. A source keeps its grant for a burst of bytes (until it marks
// a byte as last, or until max_burst bytes have gone out), so a multi-byte
// message is never interleaved with another source's bytes.
//
// Ports
//   sysclk    in   system clock
//   rst       in   synchronous active-high reset
//   req       in   [n_req]            source i has a byte waiting
//   req_data  in   [n_req*data_bits]  byte of source i at [i*data_bits +: data_bits]
//   req_last  in   [n_req]            byte of source i is the last of its message
//   ack       out  [n_req]            one-cycle pulse, byte of source i taken
//   grant     out  [n_req]            one-hot current owner, zero when idle
//   tx_data   out  [data_bits]        byte for the transmitter data register
//   tx_load   out                     one-cycle load strobe to the transmitter
//   tx_tdre   in                      transmitter data register empty
//   busy      out                     arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int data_bits      = 8,
    parameter int n_req          = 4,
    parameter int max_burst      = 16,
    parameter int burst_cnt_bits = 5
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic [n_req-1:0]           req,
    input  logic [n_req*data_bits-1:0] req_data,
    input  logic [n_req-1:0]           req_last,
    output logic [n_req-1:0]           ack,
    output logic [n_req-1:0]           grant,
    output logic [data_bits-1:0]       tx_data,
    output logic                       tx_load,
    input  logic                       tx_tdre,
    output logic                       busy
);

    localparam int IdxW = (n_req > 1) ? $clog2(n_req) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [burst_cnt_bits-1:0] MaxBurst = burst_cnt_bits'(max_burst);

    logic [1:0]                state_q, state_d;
    logic [n_req-1:0]          grant_q, grant_d;
    logic [IdxW-1:0]           owner_q, owner_d;
    logic [IdxW-1:0]           ptr_q, ptr_d;
    logic [burst_cnt_bits-1:0] burstCnt_q, burstCnt_d;
    logic                      last_q, last_d;
    logic [data_bits-1:0]      txData_q, txData_d;
    logic                      txLoad_q, txLoad_d;
    logic [n_req-1:0]          ack_q, ack_d;
    logic                      busy_q, busy_d;

    logic                      pickValid;
    logic [IdxW-1:0]           pickIdx;
    logic                      selReq;
    logic                      selLast;
    logic [data_bits-1:0]      selData;

    // Index arithmetic modulo n_req (n_req need not be a power of two).
    function automatic logic [IdxW-1:0] addWrap(input logic [IdxW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= n_req) begin
            sum = sum - n_req;
        end
        return IdxW'(sum);
    endfunction

    // Round-robin pick: first requesting source at or after the pointer,
    // wrapping past the top index back to source 0.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = 0; k < n_req; k++) begin
            if (!pickValid && req[addWrap(ptr_q, k)]) begin
                pickValid = 1'b1;
                pickIdx   = addWrap(ptr_q, k);
            end
        end
    end

    // The grant register is one-hot, so it selects the owner's request,
    // last flag and byte directly without decoding the owner index.
    always_comb begin
        selReq  = 1'b0;
        selLast = 1'b0;
        selData = '0;
        for (int i = 0; i < n_req; i++) begin
            if (grant_q[i]) begin
                selReq  = req[i];
                selLast = req_last[i];
                selData = req_data[i*data_bits +: data_bits];
            end
        end
    end

    // Next-state logic. tx_load and ack are computed one cycle early and
    // registered, so they are high exactly while the FSM sits in PULSE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        burstCnt_d = burstCnt_q;
        last_d     = last_q;
        txData_d   = txData_q;
        txLoad_d   = 1'b0;
        ack_d      = '0;

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    grant_d    = {{(n_req-1){1'b0}}, 1'b1} << pickIdx;
                    owner_d    = pickIdx;
                    burstCnt_d = '0;
                    last_d     = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // A source that withdraws its request loses the grant and
                // the next search starts just past it.
                if (!selReq) begin
                    ptr_d   = addWrap(owner_q, 1);
                    grant_d = '0;
                    state_d = IDLE;
                end else if (tx_tdre) begin
                    txData_d   = selData;
                    last_d     = selLast;
                    burstCnt_d = burstCnt_q + 1'b1;
                    txLoad_d   = 1'b1;
                    ack_d      = grant_q;
                    state_d    = PULSE;
                end
            end
            PULSE: begin
                state_d = GAP;
            end
            GAP: begin
                // Dead cycle: the source steps to its next byte and the
                // transmitter drops tdre before SEND samples it again.
                if (last_q || (burstCnt_q == MaxBurst)) begin
                    ptr_d   = addWrap(owner_q, 1);
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            burstCnt_q <= '0;
            last_q     <= 1'b0;
            txData_q   <= '0;
            txLoad_q   <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            burstCnt_q <= burstCnt_d;
            last_q     <= last_d;
            txData_q   <= txData_d;
            txLoad_q   <= txLoad_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign tx_data = txData_q;
    assign tx_load = txLoad_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Each source is a list of bytes
// with last flags; the bench presents the head byte while the list is not
// empty and steps to the next byte after ack. A transaction-level model
// walks the same lists with the round-robin/burst rules to predict the
// order of bytes on the transmitter side.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int DBITS  = 8;
    localparam int MAXB   = 4;
    localparam int QDEPTH = 32;

    logic                   sysclk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*DBITS-1:0]  req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        grant;
    logic [DBITS-1:0]       tx_data;
    logic                   tx_load;
    logic                   tx_tdre;
    logic                   busy;

    // Source lists, transmitter model and bookkeeping.
    logic [7:0]      srcData [NREQ][QDEPTH];
    logic            srcLast [NREQ][QDEPTH];
    int              srcLen  [NREQ];
    int              srcHead [NREQ];
    logic [NREQ-1:0] reqMask;
    logic            rstNext;
    int              tdreMode;
    logic            tdreFixed;
    int              txBusy;
    int              cycle;
    logic            prevLoad;
    bit              checksOn;

    int obsSrc[$];
    int obsData[$];
    int obsCycle[$];
    int expSrc[$];
    int expData[$];
    int modelPtr;

    int nAsserts;
    int nFails;
    int t0;

    uart_tx_arbiter #(
        .data_bits      (DBITS),
        .n_req          (NREQ),
        .max_burst      (MAXB),
        .burst_cnt_bits (5)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_tdre  (tx_tdre),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushByte(input int s, input logic [7:0] d, input logic l);
        srcData[s][srcLen[s]] = d;
        srcLast[s][srcLen[s]] = l;
        srcLen[s]++;
    endtask

    task automatic clearQueues();
        for (int i = 0; i < NREQ; i++) begin
            srcHead[i] = 0;
            srcLen[i]  = 0;
        end
    endtask

    // Drive every DUT input from the current source lists and tdre model.
    task automatic applyStimulus();
        rst = rstNext;
        for (int i = 0; i < NREQ; i++) begin
            if (srcHead[i] < srcLen[i] && reqMask[i]) begin
                req[i]                     = 1'b1;
                req_data[i*DBITS +: DBITS] = srcData[i][srcHead[i]];
                req_last[i]                = srcLast[i][srcHead[i]];
            end else begin
                req[i]                     = 1'b0;
                req_data[i*DBITS +: DBITS] = '0;
                req_last[i]                = 1'b0;
            end
        end
        tx_tdre = (tdreMode == 1) ? (txBusy == 0) : tdreFixed;
    endtask

    // One clock cycle: drive just after the rising edge, sample on the
    // falling edge, record loads, check pulse rules, advance sources.
    task automatic tick();
        int src;
        @(posedge sysclk);
        #1;
        applyStimulus();
        @(negedge sysclk);
        cycle++;
        if (checksOn) begin
            checkOutput("busy_vs_grant", busy, grant != '0);
            if (tx_load === 1'b1) begin
                checkOutput("ack_eq_grant", ack, grant);
                checkOutput("grant_onehot", $onehot(grant), 1);
                src = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant[i] === 1'b1) src = i;
                end
                obsSrc.push_back(src);
                obsData.push_back(int'(tx_data));
                obsCycle.push_back(cycle);
            end else begin
                checkOutput("ack_without_load", ack, 0);
            end
            checkOutput("back_to_back_load", prevLoad & tx_load, 0);
            prevLoad = (tx_load === 1'b1);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] === 1'b1 && srcHead[i] < srcLen[i]) srcHead[i]++;
            end
            if (tdreMode == 1) begin
                if (tx_load === 1'b1) txBusy = $urandom_range(1, 4);
                else if (txBusy > 0) txBusy--;
            end
        end
    endtask

    // Transaction-level reference: serve sources round-robin from the model
    // pointer; a turn ends on a last byte, after MAXB bytes, or when the
    // source runs out of bytes. The pointer then moves past that source.
    task automatic buildExpected();
        int  h [NREQ];
        int  g;
        int  cnt;
        bit  lastFlag;
        bit  more;
        for (int i = 0; i < NREQ; i++) h[i] = srcHead[i];
        expSrc.delete();
        expData.delete();
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (modelPtr + k) % NREQ;
                if (g < 0 && h[c] < srcLen[c] && reqMask[c]) g = c;
            end
            if (g < 0) begin
                more = 1'b0;
            end else begin
                cnt      = 0;
                lastFlag = 1'b0;
                while (!lastFlag && cnt < MAXB && h[g] < srcLen[g]) begin
                    expSrc.push_back(g);
                    expData.push_back(int'(srcData[g][h[g]]));
                    lastFlag = srcLast[g][h[g]];
                    h[g]++;
                    cnt++;
                end
                modelPtr = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic checkLoads(input string tag);
        checkOutput({tag, "_count"}, obsSrc.size(), expSrc.size());
        for (int i = 0; i < obsSrc.size() && i < expSrc.size(); i++) begin
            checkOutput({tag, "_src"}, obsSrc[i], expSrc[i]);
            checkOutput({tag, "_data"}, obsData[i], expData[i]);
        end
        obsSrc.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    function automatic bit allDrained();
        bit d;
        d = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (srcHead[i] < srcLen[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic runUntilIdle(input int maxCycles);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxCycles) begin
            tick();
            n++;
            done = allDrained() && (grant === '0) && (busy === 1'b0);
        end
        checkOutput("idle_timeout", done, 1);
    endtask

    task automatic waitLoad(input int maxCycles);
        int n;
        n = 0;
        while (tx_load !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("load_timeout", tx_load, 1);
    endtask

    // Directed scenarios in sequence, with randomized data and tdre timing.
    initial begin
        nAsserts  = 0;
        nFails    = 0;
        cycle     = 0;
        prevLoad  = 1'b0;
        checksOn  = 1'b0;
        reqMask   = '1;
        rstNext   = 1'b1;
        tdreMode  = 0;
        tdreFixed = 1'b1;
        txBusy    = 0;
        modelPtr  = 0;
        clearQueues();

        // Reset state.
        tick();
        tick();
        checksOn = 1'b1;
        rstNext  = 1'b0;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_tx_load", tx_load, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_busy", busy, 0);

        // Single source, three-byte message, tdre held high.
        $display("[TB] single source message");
        pushByte(0, 8'h41, 1'b0);
        pushByte(0, 8'h42, 1'b0);
        pushByte(0, 8'h43, 1'b1);
        buildExpected();
        t0 = cycle + 1;
        tick();
        tick();
        checkOutput("arb_grant", grant, 4'b0001);
        checkOutput("arb_busy", busy, 1);
        runUntilIdle(100);
        checkOutput("single_end_grant", grant, 0);
        checkOutput("single_end_busy", busy, 0);
        if (obsCycle.size() >= 3) begin
            checkOutput("first_load_latency", obsCycle[0] - t0, 2);
            checkOutput("byte_period_1", obsCycle[1] - obsCycle[0], 3);
            checkOutput("byte_period_2", obsCycle[2] - obsCycle[1], 3);
        end
        checkLoads("single");

        // Fairness: every source sends three one-byte messages.
        $display("[TB] fairness");
        clearQueues();
        tdreMode = 1;
        txBusy   = 0;
        for (int m = 0; m < 3; m++) begin
            for (int s = 0; s < NREQ; s++) pushByte(s, 8'($urandom), 1'b1);
        end
        buildExpected();
        runUntilIdle(500);
        checkLoads("fair");

        // Burst cap: source 1 streams ten bytes without last, source 2 one byte.
        $display("[TB] burst cap");
        clearQueues();
        for (int b = 0; b < 10; b++) pushByte(1, 8'($urandom), 1'b0);
        pushByte(2, 8'($urandom), 1'b1);
        buildExpected();
        runUntilIdle(500);
        if (obsSrc.size() >= 6) begin
            checkOutput("cap_other_served", obsSrc[4], 2);
            checkOutput("cap_resume_src", obsSrc[5], 1);
            checkOutput("cap_resume_data", obsData[5], int'(srcData[1][4]));
        end
        checkLoads("cap");

        // Random traffic rounds.
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random round %0d", r);
            clearQueues();
            tdreMode = ($urandom_range(0, 1) == 0) ? 0 : 1;
            tdreFixed = 1'b1;
            txBusy   = 0;
            for (int s = 0; s < NREQ; s++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int b = 0; b < n; b++) pushByte(s, 8'($urandom), $urandom_range(0, 2) == 0);
            end
            buildExpected();
            runUntilIdle(800);
            checkLoads("random");
        end

        // Backpressure: tdre low for 20 cycles after the grant.
        $display("[TB] backpressure");
        clearQueues();
        tdreMode  = 0;
        tdreFixed = 1'b0;
        pushByte(0, 8'h5A, 1'b1);
        buildExpected();
        tick();
        tick();
        checkOutput("bp_grant", grant, 4'b0001);
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("bp_no_load", tx_load, 0);
            checkOutput("bp_no_ack", ack, 0);
            checkOutput("bp_hold_grant", grant, 4'b0001);
        end
        tdreFixed = 1'b1;
        tick();
        checkOutput("bp_not_yet", tx_load, 0);
        tick();
        checkOutput("bp_load", tx_load, 1);
        checkOutput("bp_data", tx_data, 8'h5A);
        runUntilIdle(50);
        checkLoads("bp");

        // Abandon: source 3 granted, withdraws before tdre rises.
        $display("[TB] abandon");
        clearQueues();
        tdreFixed = 1'b0;
        pushByte(3, 8'hC3, 1'b1);
        tick();
        tick();
        checkOutput("ab_grant", grant, 4'b1000);
        reqMask[3] = 1'b0;
        tick();
        tick();
        checkOutput("ab_idle_grant", grant, 0);
        checkOutput("ab_idle_busy", busy, 0);
        checkOutput("ab_no_loads", obsSrc.size(), 0);
        modelPtr = (3 + 1) % NREQ;
        clearQueues();
        reqMask   = '1;
        tdreFixed = 1'b1;
        pushByte(0, 8'h10, 1'b1);
        pushByte(2, 8'h12, 1'b1);
        buildExpected();
        tick();
        tick();
        checkOutput("ab_next_grant", grant, 4'b0001);
        runUntilIdle(50);
        checkLoads("ab");

        // Reset in the cycle after a PULSE, in the middle of a message.
        $display("[TB] reset mid-burst");
        clearQueues();
        pushByte(2, 8'hA1, 1'b0);
        pushByte(2, 8'hA2, 1'b0);
        pushByte(2, 8'hA3, 1'b1);
        waitLoad(20);
        checkOutput("mid_first_data", tx_data, 8'hA1);
        pushByte(1, 8'hB1, 1'b1);
        pushByte(3, 8'hD3, 1'b1);
        rstNext = 1'b1;
        tick();
        rstNext = 1'b0;
        tick();
        checkOutput("mid_rst_grant", grant, 0);
        checkOutput("mid_rst_ack", ack, 0);
        checkOutput("mid_rst_load", tx_load, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_data", tx_data, 0);
        obsSrc.delete();
        obsData.delete();
        obsCycle.delete();
        modelPtr = 0;
        buildExpected();
        tick();
        checkOutput("mid_next_grant", grant, 4'b0010);
        runUntilIdle(100);
        checkLoads("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
